// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU with registered results and pass-through toward the memory stage.
// Define EXEC_MUL_EN to build the 32-cycle iterative shift-add multiplier (MUL op, IDLE/BUSY FSM).
module execute_stage #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         valid_in,
    input  logic [3:0]   ALUOp,
    input  logic [W-1:0] OpA,
    input  logic [W-1:0] OpB,
    input  logic [W-1:0] RdRqIn,
    input  logic         Mem_Write_in,
    input  logic         MemRead_in,
    input  logic         RegWrite_in,
    input  logic [4:0]   WriteReg_in,
    output logic [W-1:0] ALURes,
    output logic [W-1:0] RdRqOut,
    output logic         Mem_Write,
    output logic         MemRead,
    output logic         RegWrite,
    output logic [4:0]   WriteReg,
    output logic         valid_out,
    output logic         stall
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_SLT = 4'd8;
`ifdef EXEC_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd9;
`endif

    logic [W-1:0] alu_val;

    logic [W-1:0] alu_res_q, alu_res_d;
    logic [W-1:0] rd_rq_q, rd_rq_d;
    logic [4:0]   wreg_q, wreg_d;
    logic         valid_q, valid_d;
    logic         mem_write_q, mem_write_d;
    logic         mem_read_q, mem_read_d;
    logic         reg_write_q, reg_write_d;

`ifdef EXEC_MUL_EN
    typedef enum logic {IDLE, BUSY} state_t;

    state_t       state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [W-1:0] acc_q, acc_d;
    logic [W-1:0] mcand_q, mcand_d;
    logic [W-1:0] mplier_q, mplier_d;
    logic [W-1:0] l_rd_rq_q, l_rd_rq_d;
    logic [4:0]   l_wreg_q, l_wreg_d;
    logic         l_mw_q, l_mw_d;
    logic         l_mr_q, l_mr_d;
    logic         l_rw_q, l_rw_d;
    logic [W-1:0] step_sum;
    logic         stall_c;
`endif

    // MUL (and reserved codes) fall to zero here; the multiplier path overrides ALURes itself.
    always_comb begin
        alu_val = '0;
        case (ALUOp)
            OP_ADD:  alu_val = OpA + OpB;
            OP_SUB:  alu_val = OpA - OpB;
            OP_AND:  alu_val = OpA & OpB;
            OP_OR:   alu_val = OpA | OpB;
            OP_XOR:  alu_val = OpA ^ OpB;
            OP_SLL:  alu_val = OpA << OpB[4:0];
            OP_SRL:  alu_val = OpA >> OpB[4:0];
            OP_SRA:  alu_val = W'($signed(OpA) >>> OpB[4:0]);
            OP_SLT:  alu_val[0] = ($signed(OpA) < $signed(OpB));
            default: alu_val = '0;
        endcase
    end

    always_comb begin
        alu_res_d   = alu_res_q;
        rd_rq_d     = rd_rq_q;
        wreg_d      = wreg_q;
        valid_d     = valid_q;
        mem_write_d = mem_write_q;
        mem_read_d  = mem_read_q;
        reg_write_d = reg_write_q;
`ifdef EXEC_MUL_EN
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        l_rd_rq_d = l_rd_rq_q;
        l_wreg_d  = l_wreg_q;
        l_mw_d    = l_mw_q;
        l_mr_d    = l_mr_q;
        l_rw_d    = l_rw_q;
        stall_c   = 1'b0;
        step_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
        if (flush) begin
            valid_d     = 1'b0;
            mem_write_d = 1'b0;
            mem_read_d  = 1'b0;
            reg_write_d = 1'b0;
`ifdef EXEC_MUL_EN
            state_d = IDLE;
            cnt_d   = '0;
`endif
        end
`ifdef EXEC_MUL_EN
        else if (state_q == BUSY) begin
            acc_d       = step_sum;
            mcand_d     = mcand_q << 1;
            mplier_d    = mplier_q >> 1;
            cnt_d       = cnt_q + 5'd1;
            valid_d     = 1'b0;
            mem_write_d = 1'b0;
            mem_read_d  = 1'b0;
            reg_write_d = 1'b0;
            if (cnt_q == 5'd31) begin
                // Last iteration: its sum goes straight to the output, retiring the held MUL.
                state_d     = IDLE;
                cnt_d       = '0;
                alu_res_d   = step_sum;
                rd_rq_d     = l_rd_rq_q;
                wreg_d      = l_wreg_q;
                valid_d     = 1'b1;
                mem_write_d = l_mw_q;
                mem_read_d  = l_mr_q;
                reg_write_d = l_rw_q;
            end else begin
                stall_c = 1'b1;
            end
        end else if (valid_in && (ALUOp == OP_MUL)) begin
            stall_c     = 1'b1;
            state_d     = BUSY;
            cnt_d       = '0;
            acc_d       = '0;
            mcand_d     = OpA;
            mplier_d    = OpB;
            l_rd_rq_d   = RdRqIn;
            l_wreg_d    = WriteReg_in;
            l_mw_d      = Mem_Write_in;
            l_mr_d      = MemRead_in;
            l_rw_d      = RegWrite_in;
            valid_d     = 1'b0;
            mem_write_d = 1'b0;
            mem_read_d  = 1'b0;
            reg_write_d = 1'b0;
        end
`endif
        else if (valid_in) begin
            alu_res_d   = alu_val;
            rd_rq_d     = RdRqIn;
            wreg_d      = WriteReg_in;
            valid_d     = 1'b1;
            mem_write_d = Mem_Write_in;
            mem_read_d  = MemRead_in;
            reg_write_d = RegWrite_in;
        end else begin
            valid_d     = 1'b0;
            mem_write_d = 1'b0;
            mem_read_d  = 1'b0;
            reg_write_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_res_q   <= '0;
            rd_rq_q     <= '0;
            wreg_q      <= '0;
            valid_q     <= 1'b0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            reg_write_q <= 1'b0;
`ifdef EXEC_MUL_EN
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            l_rd_rq_q <= '0;
            l_wreg_q  <= '0;
            l_mw_q    <= 1'b0;
            l_mr_q    <= 1'b0;
            l_rw_q    <= 1'b0;
`endif
        end else begin
            alu_res_q   <= alu_res_d;
            rd_rq_q     <= rd_rq_d;
            wreg_q      <= wreg_d;
            valid_q     <= valid_d;
            mem_write_q <= mem_write_d;
            mem_read_q  <= mem_read_d;
            reg_write_q <= reg_write_d;
`ifdef EXEC_MUL_EN
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            l_rd_rq_q <= l_rd_rq_d;
            l_wreg_q  <= l_wreg_d;
            l_mw_q    <= l_mw_d;
            l_mr_q    <= l_mr_d;
            l_rw_q    <= l_rw_d;
`endif
        end
    end

`ifdef EXEC_MUL_EN
    assign stall = stall_c & rst;
`else
    assign stall = 1'b0;
`endif

    assign ALURes    = alu_res_q;
    assign RdRqOut   = rd_rq_q;
    assign WriteReg  = wreg_q;
    assign valid_out = valid_q;
    assign Mem_Write = mem_write_q;
    assign MemRead   = mem_read_q;
    assign RegWrite  = reg_write_q;

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Parameter: W, default 32, datapath width of operands, result and store data.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 flush  in  1  kill the instruction currently in this stage; synchronous.
REQ-005 valid_in  in  1  instruction present on inputs.
REQ-006 ALUOp  in  4  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 MUL (low W bits); 10-15 reserved.
REQ-007 OpA, OpB  in  W  operands; shift amount is OpB[4:0].
REQ-008 RdRqIn  in  W  store data, passed through.
REQ-009 Mem_Write_in, MemRead_in, RegWrite_in  in  1 each  control, passed through.
REQ-010 WriteReg_in  in  5  destination register, passed through.
REQ-011 ALURes  out  W  registered result to memory stage (address or writeback value).
REQ-012 RdRqOut  out  W  registered store data.
REQ-013 Mem_Write, MemRead, RegWrite  out  1 each  registered control, qualified by valid_out.
REQ-014 WriteReg  out  5  registered destination.
REQ-015 valid_out  out  1  registered instruction valid toward memory stage.
REQ-016 stall  out  1  combinational; upstream SHALL hold all inputs unchanged while high.

Function
REQ-017 Non-MUL ops: 1-cycle latency; result and pass-through fields registered at the edge ending the cycle in which valid_in=1 and stall=0.
REQ-018 Arithmetic: ADD/SUB modulo 2^W, carry discarded; SLT yields 1 or 0; SRA sign-fills; reserved ops yield ALURes=0 with control passed through.
REQ-019 FSM states: IDLE, BUSY; 5-bit iteration counter cnt.
REQ-020 IDLE with valid_in=1, ALUOp=MUL, flush=0: stall=1 that cycle; edge latches OpA/OpB and control, goes BUSY, cnt=0, valid_out=0.
REQ-021 BUSY: one shift-add iteration per cycle (radix-2, unsigned, low W bits kept); cnt increments; stall=1 while cnt!=31.
REQ-022 BUSY with cnt==31: stall=0; edge writes product and latched control to outputs, valid_out=1, returns IDLE; the held MUL on inputs is retired at that edge and not restarted.
REQ-023 MUL timing: stall high exactly 32 consecutive cycles starting with the presentation cycle; valid_out=1 for the MUL in the 34th cycle counted from presentation; valid_out=0 in all intermediate cycles.
REQ-024 valid_in=0 with stall=0: edge sets valid_out=0 and Mem_Write/MemRead/RegWrite=0; data outputs may hold.
REQ-025 flush=1 (any state): stall=0 same cycle; edge sets valid_out, Mem_Write, MemRead, RegWrite to 0, state IDLE, cnt=0; flush has priority over every other event.
REQ-026 Back-to-back MULs: second MUL presented in the cycle after retirement starts a new 32-cycle sequence with no extra bubble.
REQ-027 Control outputs SHALL never be 1 while valid_out=0.

Reset
REQ-028 rst=0 asynchronously forces: state IDLE, cnt=0, all outputs 0 (ALURes, RdRqOut, WriteReg, valid_out, Mem_Write, MemRead, RegWrite); stall=0 while rst=0.
REQ-029 Reset asserted mid-MUL discards the partial product; first edge after release behaves as IDLE.

Configuration
REQ-030 Macro EXEC_MUL_EN: defined -> iterative multiplier and BUSY state built as above.
REQ-031 EXEC_MUL_EN undefined -> no multiplier logic, stall tied 0, MUL treated as reserved (ALURes=0, 1-cycle latency).

Verification
REQ-032 Reset release, then ADD OpA=0x0000_0005 OpB=0xFFFF_FFFE -> next cycle ALURes=0x0000_0003, valid_out=1, stall never high.
REQ-033 SRA OpA=0x8000_0000 OpB=4 -> ALURes=0xF800_0000; SLT OpA=0xFFFF_FFFF OpB=1 -> ALURes=1.
REQ-034 MUL 0x0001_0003 x 0x0000_0010 (EXEC_MUL_EN) -> stall high 32 cycles, valid_out=0 meanwhile, then ALURes=0x0010_0030, valid_out=1 for one cycle.
REQ-035 MUL with flush pulsed at BUSY cnt=10 -> stall drops that cycle, next edge valid_out=0, RegWrite=0, following ADD completes in 1 cycle.
REQ-036 rst pulsed low mid-MUL, store with Mem_Write_in=1 presented after release -> outputs 0 during reset, then Mem_Write=1, RdRqOut equals RdRqIn one cycle later.
REQ-037 EXEC_MUL_EN undefined, MUL 3x4 -> stall=0, next cycle ALURes=0, valid_out=1.
